// File: rtl/hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit: register-file geometry,
// memory-wait timeout default and the controller state encoding.
package hazard_unit_pkg;

    localparam int unsigned RegAddrWidth      = 5;
    localparam int unsigned RegWidth          = 32;
    localparam int unsigned MemTimeoutDefault = 15;

    typedef enum logic [1:0] {
        StIdle,
        StLoadUse,
        StMemWait,
        StFlush
    } hz_state_e;

endpackage

// File: rtl/hazard_unit_if.sv
// Decode/execute/memory-stage view of the hazard unit: pipeline sources drive the
// operand and memory status, the hazard unit returns stall/flush controls.
interface hazard_unit_if;
    import hazard_unit_pkg::*;

    logic [RegAddrWidth-1:0] id_rs1_addr;
    logic [RegAddrWidth-1:0] id_rs2_addr;
    logic                    id_rs1_used;
    logic                    id_rs2_used;
    logic [RegAddrWidth-1:0] ex_rd_addr;
    logic                    ex_is_load;
    logic                    branch_taken;
    logic                    dmem_req;
    logic                    dmem_ack;

    logic                    stall_if;
    logic                    stall_id;
    logic                    stall_ex;
    logic                    stall_mem;
    logic                    flush_id;
    logic                    flush_ex;
    logic                    mem_err;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        output ex_rd_addr, ex_is_load, branch_taken, dmem_req, dmem_ack,
        input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, mem_err
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        input  ex_rd_addr, ex_is_load, branch_taken, dmem_req, dmem_ack,
        output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, mem_err
    );

endinterface

// File: rtl/hazard_unit_cmp.sv
// Single-source load-use compare: hit when a GPR-writing load in execute targets a
// register (other than x0) that this source actually reads.
module hazard_cmp
    import hazard_unit_pkg::*;
(
    input  logic [RegAddrWidth-1:0] rs,
    input  logic                    used,
    input  logic [RegAddrWidth-1:0] rd,
    input  logic                    is_load,
    output logic                    hit
);

    assign hit = is_load && used && (rd != '0) && (rs == rd);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: memory-wait stalls with timeout, branch flush and
// load-use bubble. Define HAZARD_PERF_CNT_EN to add the stall_cycles counter.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]  stall_cycles
`endif
);

    localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    hz_state_e       state_q, state_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;

    logic hit_rs1, hit_rs2, load_use, mem_wait;
    logic stall_front, stall_back, flush_front, flush_back, err;

    hazard_cmp u_cmp_rs1 (
        .rs      (hz.id_rs1_addr),
        .used    (hz.id_rs1_used),
        .rd      (hz.ex_rd_addr),
        .is_load (hz.ex_is_load),
        .hit     (hit_rs1)
    );

    hazard_cmp u_cmp_rs2 (
        .rs      (hz.id_rs2_addr),
        .used    (hz.id_rs2_used),
        .rd      (hz.ex_rd_addr),
        .is_load (hz.ex_is_load),
        .hit     (hit_rs2)
    );

    assign load_use = hit_rs1 || hit_rs2;
    assign mem_wait = hz.dmem_req && !hz.dmem_ack;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_front = 1'b0;
        stall_back  = 1'b0;
        flush_front = 1'b0;
        flush_back  = 1'b0;
        err         = 1'b0;
        unique case (state_q)
            StMemWait: begin
                // Branches and load-use are ignored here: execute is frozen.
                if (hz.dmem_ack) begin
                    state_d = StIdle;
                end else if (wait_cnt_q == CntW'(MEM_TIMEOUT)) begin
                    err     = 1'b1;
                    state_d = StIdle;
                end else begin
                    stall_front = 1'b1;
                    stall_back  = 1'b1;
                    wait_cnt_d  = wait_cnt_q + CntW'(1);
                end
            end
            StIdle, StLoadUse, StFlush: begin
                if (mem_wait) begin
                    stall_front = 1'b1;
                    stall_back  = 1'b1;
                    wait_cnt_d  = '0;
                    state_d     = StMemWait;
                end else if (state_q != StIdle) begin
                    state_d = StIdle;
                end else if (hz.branch_taken) begin
                    flush_front = 1'b1;
                    flush_back  = 1'b1;
                    state_d     = StFlush;
                end else if (load_use) begin
                    stall_front = 1'b1;
                    flush_back  = 1'b1;
                    state_d     = StLoadUse;
                end
            end
            default: state_d = StIdle;
        endcase
        if (rst) begin
            stall_front = 1'b0;
            stall_back  = 1'b0;
            flush_front = 1'b0;
            flush_back  = 1'b0;
            err         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign hz.stall_if  = stall_front;
    assign hz.stall_id  = stall_front;
    assign hz.stall_ex  = stall_back;
    assign hz.stall_mem = stall_back;
    assign hz.flush_id  = flush_front;
    assign hz.flush_ex  = flush_back;
    assign hz.mem_err   = err;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    assign stall_cycles_d = stall_cycles_q + {31'd0, stall_front};

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: behavioural model compared every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    localparam int Timeout = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_unit_if hz_if ();
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    hazard_unit #(
        .MEM_TIMEOUT (Timeout)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    int n_checks = 0;
    int n_errs   = 0;
    bit chk_en   = 1'b0;

    // Model: waiting on memory (with elapsed wait cycles) or serving a one-cycle bubble.
    bit          m_wait   = 1'b0;
    int          m_waited = 0;
    bit          m_bubble = 1'b0;
    logic [31:0] m_stalls = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, mem_err}
    function automatic logic [6:0] outs();
        return {hz_if.stall_if, hz_if.stall_id, hz_if.stall_ex, hz_if.stall_mem,
                hz_if.flush_id, hz_if.flush_ex, hz_if.mem_err};
    endfunction

    function automatic bit load_use_hit();
        logic [RegAddrWidth-1:0] rd;
        rd = hz_if.ex_rd_addr;
        if (!hz_if.ex_is_load || rd == 0) return 1'b0;
        return (hz_if.id_rs1_used && hz_if.id_rs1_addr == rd) ||
               (hz_if.id_rs2_used && hz_if.id_rs2_addr == rd);
    endfunction

    function automatic logic [6:0] model_out();
        if (rst) return 7'b0;
        if (m_wait) begin
            if (hz_if.dmem_ack) return 7'b0;
            if (m_waited >= Timeout) return 7'b0000001;
            return 7'b1111000;
        end
        if (hz_if.dmem_req && !hz_if.dmem_ack) return 7'b1111000;
        if (m_bubble) return 7'b0;
        if (hz_if.branch_taken) return 7'b0000110;
        if (load_use_hit()) return 7'b1100010;
        return 7'b0;
    endfunction

    always @(posedge clk) begin
        logic [6:0] e;
        e = model_out();
        if (rst) begin
            m_wait   <= 1'b0;
            m_waited <= 0;
            m_bubble <= 1'b0;
            m_stalls <= '0;
        end else begin
            m_stalls <= m_stalls + {31'd0, e[6]};
            if (m_wait) begin
                if (!hz_if.dmem_ack && m_waited < Timeout) m_waited <= m_waited + 1;
                else m_wait <= 1'b0;
            end else if (hz_if.dmem_req && !hz_if.dmem_ack) begin
                m_wait   <= 1'b1;
                m_waited <= 0;
                m_bubble <= 1'b0;
            end else if (m_bubble) begin
                m_bubble <= 1'b0;
            end else if (hz_if.branch_taken || load_use_hit()) begin
                m_bubble <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [6:0] o;
        if (chk_en) begin
            o = outs();
            check("model", 32'(o), 32'(model_out()));
            check("stall_flush_excl", 32'((o[5] & o[2]) | (o[4] & o[1])), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
            check("stall_cycles", stall_cycles, m_stalls);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        hz_if.id_rs1_addr  = '0;
        hz_if.id_rs2_addr  = '0;
        hz_if.id_rs1_used  = 1'b0;
        hz_if.id_rs2_used  = 1'b0;
        hz_if.ex_rd_addr   = '0;
        hz_if.ex_is_load   = 1'b0;
        hz_if.branch_taken = 1'b0;
        hz_if.dmem_req     = 1'b0;
        hz_if.dmem_ack     = 1'b0;
    endtask

    task automatic set_load_use();
        hz_if.ex_is_load  = 1'b1;
        hz_if.ex_rd_addr  = 5'd5;
        hz_if.id_rs1_addr = 5'd5;
        hz_if.id_rs1_used = 1'b1;
    endtask

    task automatic lit(input string name, input logic [6:0] exp);
        @(negedge clk);
        check(name, 32'(outs()), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        clr();
        chk_en = 1'b1;
        tick();
        tick();
        lit("reset_outputs", 7'b0);
        tick();
        rst = 1'b0;

        // lw x5 in EX, add reading x5 in ID
        set_load_use();
        lit("load_use_stall", 7'b1100010);
        tick();
        lit("load_use_bubble", 7'b0);
        tick();
        clr();

        // lw x0 must never stall
        hz_if.ex_is_load  = 1'b1;
        hz_if.id_rs1_used = 1'b1;
        lit("x0_no_stall", 7'b0);
        tick();
        clr();

        // Memory wait, ack on the fifth cycle
        hz_if.dmem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lit("mem_wait_stall", 7'b1111000);
            tick();
        end
        hz_if.dmem_ack = 1'b1;
        lit("mem_wait_ack", 7'b0);
        tick();
        clr();
        lit("mem_wait_after", 7'b0);
        tick();

        // Timeout: 16 stalled cycles then one mem_err pulse
        hz_if.dmem_req = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) lit("timeout_stall", 7'b1111000);
            else lit("timeout_err", 7'b0000001);
            tick();
        end
        hz_if.dmem_req = 1'b0;
        lit("timeout_after", 7'b0);
        tick();

        // Branch and load-use together: flush wins
        set_load_use();
        hz_if.branch_taken = 1'b1;
        lit("branch_over_load_use", 7'b0000110);
        tick();
        clr();
        lit("flush_state_quiet", 7'b0);
        tick();

        // Branch ignored in MEM_WAIT, then reset mid-wait
        hz_if.dmem_req = 1'b1;
        tick();
        hz_if.branch_taken = 1'b1;
        lit("branch_in_mem_wait", 7'b1111000);
        tick();
        hz_if.branch_taken = 1'b0;
        tick();
        rst = 1'b1;
        lit("reset_mid_wait", 7'b0);
        tick();
        rst = 1'b0;
        hz_if.dmem_req = 1'b0;
        lit("after_reset_idle", 7'b0);
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cycles_reset", stall_cycles, 32'd0);
`endif
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst                = ($urandom_range(0, 299) == 0);
            hz_if.id_rs1_addr  = 5'($urandom_range(0, 3));
            hz_if.id_rs2_addr  = 5'($urandom_range(0, 3));
            hz_if.id_rs1_used  = 1'($urandom_range(0, 1));
            hz_if.id_rs2_used  = 1'($urandom_range(0, 1));
            hz_if.ex_rd_addr   = 5'($urandom_range(0, 3));
            hz_if.ex_is_load   = 1'($urandom_range(0, 1));
            hz_if.branch_taken = ($urandom_range(0, 4) == 0);
            hz_if.dmem_req     = ($urandom_range(0, 3) == 0);
            hz_if.dmem_ack     = ($urandom_range(0, 2) == 0);
            tick();
        end

        rst = 1'b0;
        clr();
        tick();
        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
